// File: rtl/sdcontroller_mem_if_ddr3_emif_0_dmaster_st_arb.sv
// Round-robin burst arbiter merging NUM_REQ Avalon-ST byte streams into the
// single stream feeding the DDR3 EMIF debug master. Each grant lasts up to
// MAX_BURST beats. The merged beat and its source index leave through a
// registered output stage that honours out_ready.
// Optional feature macro: DMASTER_ARB_STALL_CNT_EN adds a saturating 16-bit
// stall_count output that counts cycles with out_valid && !out_ready.
module sdcontroller_mem_if_ddr3_emif_0_dmaster_st_arb #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [1:0]                out_channel,
  input  logic                      out_ready
`ifdef DMASTER_ARB_STALL_CNT_EN
  ,
  output logic [15:0]               stall_count
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]        state;
  logic [1:0]        grant_idx;
  logic [1:0]        rr_ptr;
  logic [1:0]        next_idx;
  logic [1:0]        rr_next;
  logic [7:0]        beat_cnt;
  logic [3:0]        valid_pad;
  logic [3:0]        ready_pad;
  logic [DATA_W-1:0] data_arr [4];
  logic              any_valid;
  logic              out_free;
  logic              grant_valid;
  logic              accept;
  logic              release_grant;

  // Pad requester inputs to four slots so a 2-bit index is always in range
  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_used
      assign valid_pad[g] = in_valid[g];
      assign data_arr[g]  = in_data[g*DATA_W +: DATA_W];
    end else begin : g_unused
      assign valid_pad[g] = 1'b0;
      assign data_arr[g]  = '0;
    end
  end

  // Pick the first valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    logic [1:0] cand_idx;
    cand_idx  = 2'd0;
    next_idx  = rr_ptr;
    any_valid = |in_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = 2'((int'(rr_ptr) + k) % NUM_REQ);
      if (valid_pad[cand_idx]) begin
        next_idx = cand_idx;
      end
    end
  end

  // Handshake and release decisions for the current grant
  always_comb begin
    rr_next       = (grant_idx == 2'(NUM_REQ - 1)) ? 2'd0 : grant_idx + 2'd1;
    out_free      = !out_valid || out_ready;
    grant_valid   = valid_pad[grant_idx];
    accept        = (state == GRANT) && grant_valid && out_free;
    release_grant = (state == GRANT) &&
                    ((accept && (beat_cnt == 8'(MAX_BURST - 1))) ||
                     (!grant_valid && out_free));
  end

  // Only the granted requester sees ready, and only while the output can take a beat
  always_comb begin
    ready_pad = '0;
    if (state == GRANT) begin
      ready_pad[grant_idx] = out_free;
    end
    in_ready = ready_pad[NUM_REQ-1:0];
  end

  // Arbitration FSM: grant selection, burst counting and pointer rotation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_idx <= 2'd0;
      rr_ptr    <= 2'd0;
      beat_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_idx <= next_idx;
            beat_cnt  <= 8'd0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
          if (release_grant) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: load on an accepted beat, drain when downstream takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= 2'd0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= data_arr[grant_idx];
      out_channel <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DMASTER_ARB_STALL_CNT_EN
  // Saturating count of cycles where a held beat is refused downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= 16'd0;
    end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdcontroller_mem_if_ddr3_emif_0_dmaster_st_arb.sv
// Self-checking bench for the dmaster stream arbiter (NUM_REQ=2, MAX_BURST=4).
// Directed scenarios use constant timing tables; the random scenario compares
// against a transaction-level model of round-robin bursts and a one-slot output.
// Define DMASTER_ARB_STALL_CNT_EN to also exercise stall_count.
module tb_sdcontroller_mem_if_ddr3_emif_0_dmaster_st_arb;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk;
  logic             reset_n;
  logic [NR-1:0]    in_valid;
  logic [NR*DW-1:0] in_data;
  logic [NR-1:0]    in_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_channel;
  logic             out_ready;
`ifdef DMASTER_ARB_STALL_CNT_EN
  logic [15:0]      stall_count;
`endif

  logic [7:0]    src_mem [NR][64];
  int            src_len [NR];
  int            src_pos [NR];
  int            pre_pos [NR];
  bit            src_hold [NR];
  logic [NR-1:0] s_ready;
  logic [NR-1:0] s_acc;
  logic          s_ov;
  logic [7:0]    s_od;
  logic [1:0]    s_oc;
  int            checks;
  int            errors;

  sdcontroller_mem_if_ddr3_emif_0_dmaster_st_arb #(
    .NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_channel(out_channel),
    .out_ready(out_ready)
`ifdef DMASTER_ARB_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Hard stop so a hung design can never stall the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      src_len[i]  = 0;
      src_pos[i]  = 0;
      src_hold[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_sources();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one cycle from the source tables, then sample well before the rising edge
  task automatic step(input logic rdy);
    @(negedge clk);
    out_ready = rdy;
    for (int i = 0; i < NR; i++) begin
      in_valid[i]        = (src_pos[i] < src_len[i]) && !src_hold[i];
      in_data[i*DW +: DW] = src_mem[i][src_pos[i] % 64];
      pre_pos[i]         = src_pos[i];
    end
    #1;
    s_ready = in_ready;
    s_ov    = out_valid;
    s_od    = out_data;
    s_oc    = out_channel;
    s_acc   = in_valid & in_ready;
    for (int i = 0; i < NR; i++) begin
      if (s_acc[i]) src_pos[i]++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data got %h expected 00", out_data); end
    if (out_channel !== 2'd0) begin errors++; $display("[TB] FAIL reset_out_channel got %0d expected 0", out_channel); end
    if (in_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 00", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 2'b00 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got ready=%b valid=%b expected 00/0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_source();
    logic          exp_ov;
    logic [NR-1:0] exp_rdy;
    do_reset();
    src_len[0] = 4;
    for (int k = 0; k < 4; k++) src_mem[0][k] = 8'(8'h10 + k);
    for (int t = 0; t < 8; t++) begin
      step(1'b1);
      exp_ov  = (t >= 2) && (t <= 5);
      exp_rdy = ((t >= 1) && (t <= 4)) ? 2'b01 : 2'b00;
      checks += 2;
      if (s_ov !== exp_ov) begin errors++; $display("[TB] FAIL single_out_valid t=%0d got %b expected %b", t, s_ov, exp_ov); end
      if (s_ready !== exp_rdy) begin errors++; $display("[TB] FAIL single_in_ready t=%0d got %b expected %b", t, s_ready, exp_rdy); end
      if (exp_ov) begin
        checks += 2;
        if (s_od !== 8'(8'h10 + t - 2)) begin errors++; $display("[TB] FAIL single_out_data t=%0d got %h expected %h", t, s_od, 8'(8'h10 + t - 2)); end
        if (s_oc !== 2'd0) begin errors++; $display("[TB] FAIL single_out_channel t=%0d got %0d expected 0", t, s_oc); end
      end
    end
  endtask

  task automatic test_round_robin();
    int p;
    logic       exp_ov;
    logic [1:0] exp_oc;
    logic [7:0] exp_od;
    do_reset();
    src_len[0] = 12;
    src_len[1] = 12;
    for (int k = 0; k < 12; k++) begin
      src_mem[0][k] = 8'(8'h20 + k);
      src_mem[1][k] = 8'(8'h40 + k);
    end
    for (int t = 0; t < 16; t++) begin
      step(1'b1);
      if (t >= 2) begin
        p = t - 2;
        exp_ov = 1'b1;
        exp_oc = 2'd0;
        exp_od = 8'h00;
        if (p <= 3) begin exp_od = 8'(8'h20 + p); end
        else if (p == 4 || p == 9) begin exp_ov = 1'b0; end
        else if (p <= 8) begin exp_oc = 2'd1; exp_od = 8'(8'h40 + p - 5); end
        else begin exp_od = 8'(8'h20 + 4 + p - 10); end
        checks++;
        if (s_ov !== exp_ov) begin errors++; $display("[TB] FAIL rr_out_valid t=%0d got %b expected %b", t, s_ov, exp_ov); end
        if (exp_ov) begin
          checks += 2;
          if (s_oc !== exp_oc) begin errors++; $display("[TB] FAIL rr_out_channel t=%0d got %0d expected %0d", t, s_oc, exp_oc); end
          if (s_od !== exp_od) begin errors++; $display("[TB] FAIL rr_out_data t=%0d got %h expected %h", t, s_od, exp_od); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    int   n;
    do_reset();
    src_len[0] = 8;
    for (int k = 0; k < 8; k++) src_mem[0][k] = 8'(8'h60 + k);
    n = 0;
    for (int t = 0; t < 30; t++) begin
      rdy = !((t >= 4) && (t <= 8));
      step(rdy);
      if (!rdy) begin
        checks += 3;
        if (s_ov !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid t=%0d got %b expected 1", t, s_ov); end
        if (s_od !== src_mem[0][src_pos[0] - 1]) begin errors++; $display("[TB] FAIL bp_out_data t=%0d got %h expected %h", t, s_od, src_mem[0][src_pos[0] - 1]); end
        if (s_ready !== 2'b00) begin errors++; $display("[TB] FAIL bp_in_ready t=%0d got %b expected 00", t, s_ready); end
      end
      if (s_ov && rdy) begin
        checks++;
        if (n >= 8 || s_od !== src_mem[0][n % 64] || s_oc !== 2'd0) begin
          errors++;
          $display("[TB] FAIL bp_beat n=%0d got %h ch%0d expected %h ch0", n, s_od, s_oc, src_mem[0][n % 64]);
        end
        n++;
      end
    end
    checks++;
    if (n !== 8) begin errors++; $display("[TB] FAIL bp_beat_count got %0d expected 8", n); end
  endtask

  task automatic test_early_release();
    logic [1:0] er [7];
    logic       eov [7];
    logic [1:0] eoc [7];
    logic [7:0] eod [7];
    er  = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    eov = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    eoc = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    eod = '{8'h00, 8'h00, 8'h90, 8'h91, 8'h00, 8'h00, 8'h80};
    do_reset();
    src_len[0] = 3;
    src_len[1] = 2;
    for (int k = 0; k < 3; k++) src_mem[0][k] = 8'(8'h80 + k);
    for (int k = 0; k < 2; k++) src_mem[1][k] = 8'(8'h90 + k);
    src_hold[0] = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if (t == 1) src_hold[0] = 1'b0;
      step(1'b1);
      checks += 2;
      if (s_ready !== er[t]) begin errors++; $display("[TB] FAIL early_in_ready t=%0d got %b expected %b", t, s_ready, er[t]); end
      if (s_ov !== eov[t]) begin errors++; $display("[TB] FAIL early_out_valid t=%0d got %b expected %b", t, s_ov, eov[t]); end
      if (eov[t]) begin
        checks++;
        if (s_oc !== eoc[t] || s_od !== eod[t]) begin
          errors++;
          $display("[TB] FAIL early_out_beat t=%0d got %h ch%0d expected %h ch%0d", t, s_od, s_oc, eod[t], eoc[t]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    src_len[0] = 4;
    src_len[1] = 6;
    for (int k = 0; k < 6; k++) begin
      src_mem[0][k] = 8'(8'hA0 + k);
      src_mem[1][k] = 8'(8'hB0 + k);
    end
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      step(1'b1);
      if (s_ov && s_oc == 2'd1) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL areset_wait got no ch1 beat expected one within 30 cycles"); end
    reset_n  = 1'b0;
    in_valid = '0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_out_valid got %b expected 0", out_valid); end
    if (in_ready !== 2'b00) begin errors++; $display("[TB] FAIL areset_in_ready got %b expected 00", in_ready); end
    @(negedge clk);
    clear_sources();
    src_len[0] = 2;
    src_len[1] = 2;
    for (int k = 0; k < 2; k++) begin
      src_mem[0][k] = 8'(8'hC0 + k);
      src_mem[1][k] = 8'(8'hD0 + k);
    end
    reset_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step(1'b1);
      if (t == 1) begin
        checks++;
        if (s_ready !== 2'b01) begin errors++; $display("[TB] FAIL areset_regrant got %b expected 01", s_ready); end
      end
      if (t == 2) begin
        checks++;
        if (s_ov !== 1'b1 || s_oc !== 2'd0 || s_od !== 8'hC0) begin
          errors++;
          $display("[TB] FAIL areset_first_beat got v%b %h ch%0d expected v1 c0 ch0", s_ov, s_od, s_oc);
        end
      end
    end
  endtask

  task automatic test_random();
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_oc;
    logic       rdy;
    int         cur_ch;
    int         run;
    int         g;
    int         e;
    bit         need_new;
    bit         done;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      src_len[i] = int'($urandom_range(1, 20));
      for (int k = 0; k < 64; k++) src_mem[i][k] = 8'($urandom);
    end
    exp_ov = 1'b0; exp_od = 8'h00; exp_oc = 2'd0;
    cur_ch = NR - 1; run = 0; need_new = 1'b1; done = 1'b0;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      step(rdy);
      checks++;
      if (s_ov !== exp_ov) begin errors++; $display("[TB] FAIL rand_out_valid cyc=%0d got %b expected %b", cyc, s_ov, exp_ov); end
      if (exp_ov) begin
        checks++;
        if (s_od !== exp_od || s_oc !== exp_oc) begin
          errors++;
          $display("[TB] FAIL rand_out_beat cyc=%0d got %h ch%0d expected %h ch%0d", cyc, s_od, s_oc, exp_od, exp_oc);
        end
      end
      checks++;
      if ($countones(s_ready) > 1 || (exp_ov && !rdy && s_ready !== 2'b00)) begin
        errors++;
        $display("[TB] FAIL rand_in_ready cyc=%0d got %b expected onehot and 00 when stalled", cyc, s_ready);
      end
      if (s_acc != '0) begin
        g = 0;
        for (int i = 0; i < NR; i++) if (s_acc[i]) g = i;
        if (need_new || run == MB) begin
          e = -1;
          for (int k = 1; k <= NR; k++) begin
            if (e < 0 && pre_pos[(cur_ch + k) % NR] < src_len[(cur_ch + k) % NR]) e = (cur_ch + k) % NR;
          end
          run = 1;
          need_new = 1'b0;
        end else begin
          e = cur_ch;
          run++;
        end
        checks++;
        if (g != e) begin errors++; $display("[TB] FAIL rand_grant cyc=%0d got ch%0d expected ch%0d", cyc, g, e); end
        cur_ch = g;
        if (src_pos[g] >= src_len[g]) need_new = 1'b1;
        exp_ov = 1'b1;
        exp_od = src_mem[g][pre_pos[g] % 64];
        exp_oc = 2'(g);
      end else if (exp_ov && rdy) begin
        exp_ov = 1'b0;
      end
      done = !exp_ov;
      for (int i = 0; i < NR; i++) if (src_pos[i] < src_len[i]) done = 1'b0;
    end
    checks++;
    if (!done) begin errors++; $display("[TB] FAIL rand_drain got pending beats expected all delivered within 1000 cycles"); end
  endtask

`ifdef DMASTER_ARB_STALL_CNT_EN
  task automatic test_stall_count();
    logic rdy;
    do_reset();
    src_len[0] = 1;
    src_mem[0][0] = 8'hEE;
    for (int t = 0; t < 10; t++) begin
      rdy = !((t >= 2) && (t <= 8));
      step(rdy);
      if (t == 2) begin
        checks++;
        if (s_ov !== 1'b1) begin errors++; $display("[TB] FAIL stall_precond got %b expected 1", s_ov); end
      end
      if (t == 9) begin
        checks++;
        if (stall_count !== 16'd7) begin errors++; $display("[TB] FAIL stall_count got %0d expected 7", stall_count); end
      end
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    clk       = 1'b0;
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_sources();
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_async_reset();
    test_random();
    test_random();
`ifdef DMASTER_ARB_STALL_CNT_EN
    test_stall_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
